// File: rtl/mood_update_arbiter.sv
// Round-robin arbiter that turns granted step requests into paced inc/dec pulses
// on a shared saturating counter, with clear/abort handling. All outputs are registered.
module mood_update_arbiter #(
    parameter int N    = 8,
    parameter int NREQ = 4,
    parameter int GAP  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_dir,
    input  logic [4*NREQ-1:0] req_steps,
    input  logic              clear,
    input  logic [N-1:0]      cnt_value,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   req_done,
    output logic              sat_hit,
    output logic              aborted,
    output logic              cnt_inc,
    output logic              cnt_dec,
    output logic              cnt_setval,
    output logic              busy
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int GW  = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0]  GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [N-1:0]   CNT_MAX  = '1;
    localparam logic [N-1:0]   CNT_NEAR = CNT_MAX - N'(1);

    typedef enum logic [2:0] {IDLE, PULSE, GAPW, DONE, CLEAR} state_t;

    state_t            state_q, state_d;
    logic [IDW-1:0]    id_q, id_d;
    logic [IDW-1:0]    last_q, last_d;
    logic              dir_q, dir_d;
    logic [3:0]        rem_q, rem_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              sat_flag_q, sat_flag_d;
    logic              abort_q, abort_d;
    logic [NREQ-1:0]   req_ready_q, req_ready_d;
    logic [NREQ-1:0]   req_done_q, req_done_d;
    logic              sat_hit_q, sat_hit_d;
    logic              aborted_q, aborted_d;
    logic              cnt_inc_q, cnt_inc_d;
    logic              cnt_dec_q, cnt_dec_d;
    logic              cnt_setval_q, cnt_setval_d;
    logic              busy_q, busy_d;

    logic              found;
    logic [IDW-1:0]    win;
    logic [3:0]        win_steps;
    logic              at_limit;

    // Round-robin search starting just after the last completed grant.
    always_comb begin
        found = 1'b0;
        win   = last_q;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            int unsigned cand;
            cand = (32'(last_q) + i) % NREQ;
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = IDW'(cand);
            end
        end
        win_steps = req_steps[{win, 2'b00} +: 4];
    end

    // A pulse issued last cycle is visible now but not yet reflected in cnt_value,
    // so it is counted when deciding whether the next pulse would overshoot.
    always_comb begin
        if (dir_q)
            at_limit = (cnt_value == CNT_MAX) || (cnt_inc_q && cnt_value == CNT_NEAR);
        else
            at_limit = (cnt_value == '0) || (cnt_dec_q && cnt_value == N'(1));
    end

    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        last_d       = last_q;
        dir_d        = dir_q;
        rem_d        = rem_q;
        gap_d        = gap_q;
        sat_flag_d   = sat_flag_q;
        abort_d      = abort_q;
        req_ready_d  = '0;
        req_done_d   = '0;
        sat_hit_d    = 1'b0;
        aborted_d    = 1'b0;
        cnt_inc_d    = 1'b0;
        cnt_dec_d    = 1'b0;
        cnt_setval_d = 1'b0;

        case (state_q)
            IDLE: begin
                sat_flag_d = 1'b0;
                abort_d    = 1'b0;
                if (clear) begin
                    state_d = CLEAR;
                end else if (found) begin
                    id_d        = win;
                    dir_d       = req_dir[win];
                    rem_d       = win_steps;
                    req_ready_d = NREQ'(1) << win;
                    state_d     = (win_steps == 4'd0) ? DONE : PULSE;
                end
            end
            PULSE: begin
                if (clear) begin
                    abort_d = 1'b1;
                    state_d = CLEAR;
                end else if (at_limit) begin
                    sat_flag_d = 1'b1;
                    state_d    = DONE;
                end else begin
                    cnt_inc_d = dir_q;
                    cnt_dec_d = !dir_q;
                    rem_d     = rem_q - 4'd1;
                    if (rem_q == 4'd1) begin
                        state_d = DONE;
                    end else if (GAP > 0) begin
                        gap_d   = GAP_LAST;
                        state_d = GAPW;
                    end else begin
                        state_d = PULSE;
                    end
                end
            end
            GAPW: begin
                if (clear) begin
                    abort_d = 1'b1;
                    state_d = CLEAR;
                end else if (gap_q == '0) begin
                    state_d = PULSE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            DONE: begin
                req_done_d = NREQ'(1) << id_q;
                sat_hit_d  = sat_flag_q;
                last_d     = id_q;
                state_d    = IDLE;
            end
            CLEAR: begin
                cnt_setval_d = 1'b1;
                if (abort_q) begin
                    req_done_d = NREQ'(1) << id_q;
                    aborted_d  = 1'b1;
                    last_d     = id_q;
                end
                abort_d = 1'b0;
                rem_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            id_q         <= '0;
            last_q       <= IDW'(NREQ - 1);
            dir_q        <= 1'b0;
            rem_q        <= '0;
            gap_q        <= '0;
            sat_flag_q   <= 1'b0;
            abort_q      <= 1'b0;
            req_ready_q  <= '0;
            req_done_q   <= '0;
            sat_hit_q    <= 1'b0;
            aborted_q    <= 1'b0;
            cnt_inc_q    <= 1'b0;
            cnt_dec_q    <= 1'b0;
            cnt_setval_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            last_q       <= last_d;
            dir_q        <= dir_d;
            rem_q        <= rem_d;
            gap_q        <= gap_d;
            sat_flag_q   <= sat_flag_d;
            abort_q      <= abort_d;
            req_ready_q  <= req_ready_d;
            req_done_q   <= req_done_d;
            sat_hit_q    <= sat_hit_d;
            aborted_q    <= aborted_d;
            cnt_inc_q    <= cnt_inc_d;
            cnt_dec_q    <= cnt_dec_d;
            cnt_setval_q <= cnt_setval_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign req_done   = req_done_q;
    assign sat_hit    = sat_hit_q;
    assign aborted    = aborted_q;
    assign cnt_inc    = cnt_inc_q;
    assign cnt_dec    = cnt_dec_q;
    assign cnt_setval = cnt_setval_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_mood_update_arbiter.sv
// Scoreboard bench for mood_update_arbiter: directed requests against a saturating
// counter model; a negedge monitor pops expected grants/completions as they appear.
module tb_mood_update_arbiter;

    localparam int N    = 8;
    localparam int NREQ = 4;
    localparam int GAP  = 1;
    localparam logic [7:0] SETV = 8'h80;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] req_dir;
    logic [4*NREQ-1:0] req_steps;
    logic            clear;
    logic [N-1:0]    cnt;
    logic [NREQ-1:0] req_ready, req_done;
    logic            sat_hit, aborted, cnt_inc, cnt_dec, cnt_setval, busy;

    logic            load_en = 1'b0;
    logic [N-1:0]    load_val = '0;

    mood_update_arbiter #(.N(N), .NREQ(NREQ), .GAP(GAP)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_dir(req_dir),
        .req_steps(req_steps), .clear(clear), .cnt_value(cnt),
        .req_ready(req_ready), .req_done(req_done), .sat_hit(sat_hit),
        .aborted(aborted), .cnt_inc(cnt_inc), .cnt_dec(cnt_dec),
        .cnt_setval(cnt_setval), .busy(busy)
    );

    always #5 clk = ~clk;

    // Shared saturating counter driven by the arbiter.
    initial cnt = '0;
    always @(posedge clk) begin
        if (load_en)                        cnt <= load_val;
        else if (cnt_setval)                cnt <= SETV;
        else if (cnt_inc && cnt != 8'hFF)   cnt <= cnt + 8'd1;
        else if (cnt_dec && cnt != 8'h00)   cnt <= cnt - 8'd1;
    end

    typedef struct {
        int id; bit sat; bit ab; bit sv; int pulses; bit dir; int lat;
    } exp_t;

    exp_t done_q[$];
    int   ready_q[$];
    int   checks = 0;
    int   passes = 0;
    int   exp_sv = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic exp_t mk(int id, bit sat, bit ab, bit sv, int pulses, bit dir, int lat);
        exp_t e;
        e.id = id; e.sat = sat; e.ab = ab; e.sv = sv;
        e.pulses = pulses; e.dir = dir; e.lat = lat;
        return e;
    endfunction

    // Monitor
    int cyc = 0, ready_cyc = 0, first_pc = -1, last_pc = 0;
    int inc_n = 0, dec_n = 0, sv_n = 0;
    bit spacing_bad = 0;

    always @(negedge clk) begin
        cyc++;
        if (req_ready != '0) begin
            if (ready_q.size() == 0) check("ready_unexpected", int'(req_ready), 0);
            else check("ready_id", int'(req_ready), 1 << ready_q.pop_front());
            ready_cyc = cyc; inc_n = 0; dec_n = 0; first_pc = -1; spacing_bad = 0;
        end
        if (cnt_inc || cnt_dec || cnt_setval)
            check("cnt_ctrl_exclusive", int'(cnt_inc) + int'(cnt_dec) + int'(cnt_setval), 1);
        if (cnt_inc || cnt_dec) begin
            if (first_pc < 0) first_pc = cyc;
            else if (cyc - last_pc != GAP + 1) spacing_bad = 1;
            last_pc = cyc;
            inc_n += int'(cnt_inc);
            dec_n += int'(cnt_dec);
        end
        if (cnt_setval) sv_n++;
        if (req_done != '0) begin
            if (done_q.size() == 0) begin
                check("done_unexpected", int'(req_done), 0);
            end else begin
                exp_t e;
                e = done_q.pop_front();
                check("done_id", int'(req_done), 1 << e.id);
                check("done_flags_sat_abort_setval", int'({sat_hit, aborted, cnt_setval}),
                      int'({e.sat, e.ab, e.sv}));
                check("pulse_count", e.dir ? inc_n : dec_n, e.pulses);
                check("wrong_dir_pulses", e.dir ? dec_n : inc_n, 0);
                check("done_latency", cyc - ready_cyc, e.lat);
                if (e.pulses > 0) begin
                    check("first_pulse_offset", first_pc - ready_cyc, 1);
                    check("pulse_spacing_bad", int'(spacing_bad), 0);
                end
            end
        end
    end

    task automatic load(input logic [7:0] v);
        @(negedge clk); load_en = 1'b1; load_val = v;
        @(negedge clk); load_en = 1'b0;
    endtask

    task automatic wait_grants(input int n, input bit keep);
        int got = 0;
        for (int k = 0; k < 200 && got < n; k++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++)
                if (req_ready[i]) begin
                    got++;
                    if (!keep) req_valid[i] = 1'b0;
                end
        end
        if (got < n) check("grant_timeout", got, n);
        req_valid = '0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk);
            if (!busy && done_q.size() == 0 && ready_q.size() == 0) ok = 1;
        end
        if (!ok) check("idle_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input bit dir, input logic [3:0] steps);
        req_dir[i] = dir;
        req_steps[4*i +: 4] = steps;
        req_valid[i] = 1'b1;
    endtask

    function automatic int outs();
        return int'({req_ready, req_done, sat_hit, aborted, cnt_inc, cnt_dec, cnt_setval, busy});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_valid = '0; req_dir = '0; req_steps = '0; clear = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", outs(), 0);
        rst = 1'b0;

        // clear from IDLE: one setval, no completion
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        exp_sv++;
        wait_idle();
        check("cnt_after_idle_clear", int'(cnt), int'(SETV));

        // req0 inc 3 from 10
        load(8'd10);
        ready_q.push_back(0); done_q.push_back(mk(0, 0, 0, 0, 3, 1, 6));
        set_req(0, 1'b1, 4'd3);
        wait_grants(1, 0); wait_idle();
        check("cnt_after_inc3", int'(cnt), 13);

        // req1 dec 5 from 2: saturates at zero after two pulses
        load(8'd2);
        ready_q.push_back(1); done_q.push_back(mk(1, 1, 0, 0, 2, 0, 6));
        set_req(1, 1'b0, 4'd5);
        wait_grants(1, 0); wait_idle();
        check("cnt_after_dec_sat", int'(cnt), 0);

        // req2 zero steps
        ready_q.push_back(2); done_q.push_back(mk(2, 0, 0, 0, 0, 1, 1));
        set_req(2, 1'b1, 4'd0);
        wait_grants(1, 0); wait_idle();
        check("cnt_after_zero_steps", int'(cnt), 0);

        // req1 inc 5 from 0xFE: one pulse then top saturation
        load(8'hFE);
        ready_q.push_back(1); done_q.push_back(mk(1, 1, 0, 0, 1, 1, 4));
        set_req(1, 1'b1, 4'd5);
        wait_grants(1, 0); wait_idle();
        check("cnt_after_inc_sat", int'(cnt), 255);

        // round-robin after reset with all four held valid
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        load(8'd100);
        for (int i = 0; i < 5; i++) begin
            ready_q.push_back(i % NREQ);
            done_q.push_back(mk(i % NREQ, 0, 0, 0, 1, 1, 2));
        end
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 4'd1);
        wait_grants(5, 1); wait_idle();
        check("cnt_after_rr", int'(cnt), 105);

        // clear during GAPW of req3, then req0 wins over req3
        load(8'd50);
        ready_q.push_back(3); done_q.push_back(mk(3, 0, 1, 1, 1, 1, 3));
        exp_sv++;
        set_req(3, 1'b1, 4'd4);
        wait_grants(1, 0);
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        wait_idle();
        check("cnt_after_abort_clear", int'(cnt), int'(SETV));
        ready_q.push_back(0); done_q.push_back(mk(0, 0, 0, 0, 1, 1, 2));
        ready_q.push_back(3); done_q.push_back(mk(3, 0, 0, 0, 1, 1, 2));
        set_req(0, 1'b1, 4'd1);
        set_req(3, 1'b1, 4'd1);
        wait_grants(2, 0); wait_idle();
        check("cnt_after_post_clear", int'(cnt), int'(SETV) + 2);

        // reset during PULSE: everything drops, no done, counter untouched
        load(8'd10);
        ready_q.push_back(1);
        set_req(1, 1'b1, 4'd5);
        wait_grants(1, 0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_abort_outputs", outs(), 0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("cnt_untouched_by_rst", int'(cnt), 10);

        check("scoreboard_empty", done_q.size() + ready_q.size(), 0);
        check("setval_count", sv_n, exp_sv);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
